// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and sequencing controller for the 5-stage MIPS pipeline. It produces
//   the PC / IF/ID enables, the IF/ID and ID/EX flushes and the back-end freeze.
//   It also runs the multi-cycle mult/div sequencer that gates HI/LO consumers.
//
// Parameters
//   MUL_CYCLES  mult latency in cycles (>=1)
//   DIV_CYCLES  div latency in cycles (>=MUL_CYCLES)
//   CNT_W       width of the saturating stall counter
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   id_rs/id_rt      source registers of the ID instruction
//   id_use_rs/_rt    ID instruction really reads rs / rt
//   id_md_use        ID instruction is mfhi/mflo/mult/div
//   id_jump          jump decoded in ID
//   ex_mem_read      EX instruction is a load
//   ex_rt            load destination in EX
//   ex_branch_taken  branch resolved taken in EX
//   ex_md_start      EX instruction starts mult/div
//   ex_md_div        1 = div, 0 = mult (qualifies ex_md_start)
//   mem_ready        data memory ready, 0 = wait
//   pc_en, ifid_en   front-end write enables
//   ifid_flush       clear IF/ID to nop
//   idex_flush       insert bubble into ID/EX
//   pipe_freeze      hold ID/EX, EX/MEM, MEM/WB
//   md_busy          mult/div unit running
//   md_done          HI/LO written at this edge
//   md_overlap       sticky: start seen while busy
//   stall_cnt        saturating count of cycles with pc_en=0
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_md_use,
   input  logic             id_jump,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             ex_branch_taken,
   input  logic             ex_md_start,
   input  logic             ex_md_div,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             pipe_freeze,
   output logic             md_busy,
   output logic             md_done,
   output logic             md_overlap,
   output logic [CNT_W-1:0] stall_cnt
);

   // Counter must hold DIV_CYCLES-1; the +1 keeps the width sane for latency 1.
   localparam int MDC_W = $clog2(DIV_CYCLES + 1);
   localparam logic [MDC_W-1:0] MUL_LOAD = MDC_W'(MUL_CYCLES - 1);
   localparam logic [MDC_W-1:0] DIV_LOAD = MDC_W'(DIV_CYCLES - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } md_state_t;

   md_state_t        r_state;
   md_state_t        w_state_nxt;
   logic [MDC_W-1:0] r_md_cnt;
   logic [MDC_W-1:0] w_md_cnt_nxt;
   logic             r_md_overlap;
   logic [CNT_W-1:0] r_stall_cnt;

   logic             w_md_done;
   logic             w_overlap_set;
   logic             w_md_busy;
   logic             w_load_use;
   logic             w_md_stall;

   // ---------------------------------------------------------------------------
   // mult/div sequencer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_md_cnt     <= '0;
         r_md_overlap <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_md_cnt     <= w_md_cnt_nxt;
         if (w_overlap_set)
            r_md_overlap <= 1'b1;
      end
   end

   // Starts are only accepted while memory is ready (a frozen EX instruction
   // will present its start again). The count itself runs through freezes.
   always_comb begin
      w_state_nxt   = r_state;
      w_md_cnt_nxt  = r_md_cnt;
      w_md_done     = 1'b0;
      w_overlap_set = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mem_ready && ex_md_start) begin
               w_state_nxt  = S_BUSY;
               w_md_cnt_nxt = ex_md_div ? DIV_LOAD : MUL_LOAD;
            end
         end
         S_BUSY: begin
            w_md_done = (r_md_cnt == '0);
            if (w_md_done)
               w_state_nxt = S_IDLE;
            else
               w_md_cnt_nxt = r_md_cnt - 1'b1;
            // A second start while running is dropped and flagged.
            if (mem_ready && ex_md_start)
               w_overlap_set = 1'b1;
         end
         default: begin
            w_state_nxt  = S_IDLE;
            w_md_cnt_nxt = '0;
         end
      endcase
   end

   assign w_md_busy = (r_state == S_BUSY);

   // ---------------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------------
   assign w_load_use = ex_mem_read && (ex_rt != 5'd0) &&
                       ((id_use_rs && (id_rs == ex_rt)) ||
                        (id_use_rt && (id_rt == ex_rt)));

   // In the done cycle HI/LO is written at the edge, so the consumer may go.
   assign w_md_stall = id_md_use && w_md_busy && !w_md_done;

   // ---------------------------------------------------------------------------
   // Stage control, first match wins
   // ---------------------------------------------------------------------------
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      pipe_freeze = 1'b0;
      if (!reset) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (!mem_ready) begin
         // A taken branch stays in EX under the freeze and is acted on later.
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         pipe_freeze = 1'b1;
      end else if (ex_branch_taken) begin
         // ID holds a wrong-path instruction, so any stall it asks for is moot.
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (w_load_use || w_md_stall) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (id_jump) begin
         ifid_flush = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Stall performance counter (saturating)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_stall_cnt <= '0;
      else if (!pc_en && (r_stall_cnt != {CNT_W{1'b1}}))
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   assign md_busy    = w_md_busy;
   assign md_done    = w_md_done;
   assign md_overlap = r_md_overlap;
   assign stall_cnt  = r_stall_cnt;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It generates the stage enable and flush signals: load-use stalls, branch/jump flushes and memory-wait freezes. It also sequences the multi-cycle mult/div unit through a busy counter, stalling ID whenever an instruction needs HI/LO before the result is ready. It sits beside the decode control unit and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register enables.

## Interface
- MUL_CYCLES, 4, mult latency in cycles (≥1)
- DIV_CYCLES, 32, div latency in cycles (≥MUL_CYCLES)
- CNT_W, 16, width of stall performance counter

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt
- id_md_use  in  1  ID instruction is mfhi/mflo/mult/div
- id_jump  in  1  jump decoded in ID
- ex_mem_read  in  1  EX instruction is a load
- ex_rt  in  5  load destination register in EX
- ex_branch_taken  in  1  branch resolved taken in EX
- ex_md_start  in  1  EX instruction is mult/div
- ex_md_div  in  1  qualifies ex_md_start: 1 = div, 0 = mult
- mem_ready  in  1  data memory ready; 0 = wait
- pc_en  out  1  PC write enable
- ifid_en  out  1  IF/ID write enable
- ifid_flush  out  1  clear IF/ID to nop
- idex_flush  out  1  insert bubble into ID/EX
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- md_busy  out  1  mult/div unit running
- md_done  out  1  one-cycle pulse: HI/LO written at this edge
- md_overlap  out  1  sticky error: start received while busy
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

## Operation
- md FSM, two states:
  - IDLE: on mem_ready=1 and ex_md_start=1, load md_cnt = (ex_md_div ? DIV_CYCLES : MUL_CYCLES) − 1 and go to BUSY.
  - BUSY: decrement md_cnt each cycle, regardless of mem_ready. md_done = BUSY && md_cnt==0. When md_done=1, return to IDLE.
  - md_busy = (state==BUSY).
  - ex_md_start in BUSY with mem_ready=1 sets md_overlap (sticky until reset). The FSM ignores that start.
- Hazard terms:
  - load_use = ex_mem_read && ex_rt≠0 && ((id_use_rs && id_rs==ex_rt) || (id_use_rt && id_rt==ex_rt))
  - md_stall = id_md_use && md_busy && !md_done
- Output priority, first match wins:
  1. mem_ready=0 → pipe_freeze=1, pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=0. A pending ex_branch_taken is held in EX and acted on once mem_ready=1.
  2. ex_branch_taken → pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1. This overrides the stalls because the ID instruction is on the wrong path.
  3. load_use or md_stall → pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0.
  4. id_jump → pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=0.
  5. otherwise → pc_en=1, ifid_en=1, all flush/freeze 0.
- stall_cnt: +1 on every cycle with pc_en=0 (freeze, load-use or md stall). It saturates at all-ones.

## Timing
- Enables, flushes and freeze are combinational from the inputs and FSM state. They take effect at the next rising edge.
- Mult started at edge E: md_busy is high for cycles E+1 … E+MUL_CYCLES, and md_done is high in cycle E+MUL_CYCLES.
  - A dependent mfhi held in ID is released in the md_done cycle and reaches EX on the following edge.
- Div timing is identical with DIV_CYCLES.
- A load-use stall lasts exactly 1 cycle unless extended by mem_ready=0.
- Reset low, asynchronous:
  - State goes to IDLE, md_cnt=0, md_overlap=0, stall_cnt=0.
  - While reset is low: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, pipe_freeze=0, md_busy=0, md_done=0.
  - Reset mid-divide abandons the operation with no md_done.
- Reset release: normal evaluation from the first rising edge after deassertion.
- Load destination $0 never stalls.
- md_done coinciding with mem_ready=0: the FSM still returns to IDLE. Priority 1 still governs the outputs.

## Test plan
- Load-use: lw $5 in EX (ex_mem_read=1, ex_rt=5), ID has id_rs=5, id_use_rs=1 → exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1.
- $0 load: same stimulus with ex_rt=0 → no stall; pc_en=1 throughout.
- Mult then mfhi: ex_md_start=1, ex_md_div=0 at edge E, id_md_use=1 from E+1 → md_stall for cycles E+1…E+3, release at E+4 with md_done=1; stall_cnt=3.
- Div with memory wait: div started, mem_ready=0 for 5 cycles mid-count → pipe_freeze=1 for those cycles, md_done still at start+32.
- Branch over load-use: ex_branch_taken=1 together with a load_use condition → ifid_flush=1, idex_flush=1, pc_en=1. Next: start while BUSY → md_overlap=1, stays 1.
- Reset mid-div: assert reset at busy cycle 10 → md_busy=0 immediately, stall_cnt=0; after release a new mult completes in 4 cycles.
